// File: rtl/shift_size_inverse.sv
// shift_size_inverse: sequential inverse of the triangular shift schedule.
// Finds the smallest t with (t+1)(t+2)/2 >= target, one increment per cycle.
module shift_size_inverse #(
    parameter int TW = 6,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [TW-1:0] target,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] loop_num,
    output logic          exact,
    output logic          err
);

    // Wide enough that s never wraps for any TW/LW pairing.
    localparam int SW = ((TW > 2 * LW) ? TW : 2 * LW) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] tgt;
    logic [LW-1:0] t;
    logic [SW-1:0] s;
    logic [SW-1:0] tgt_ext;
    logic [SW-1:0] t_ext;
    logic          hit;
    logic          last;

    assign tgt_ext = {{(SW - TW){1'b0}}, tgt};
    assign t_ext   = {{(SW - LW){1'b0}}, t};
    assign hit     = (s >= tgt_ext);
    assign last    = (t == {LW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = CALC;
                end
            end
            CALC: begin
                if (hit || last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt      <= '0;
            t        <= '0;
            s        <= '0;
            loop_num <= '0;
            exact    <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tgt   <= target;
                        t     <= '0;
                        s     <= SW'(1);
                        exact <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                CALC: begin
                    if (hit) begin
                        loop_num <= t;
                        exact    <= (s == tgt_ext);
                        err      <= 1'b0;
                    end else if (last) begin
                        loop_num <= t;
                        exact    <= 1'b0;
                        err      <= 1'b1;
                    end else begin
                        // next triangular number: T(t+1) = T(t) + (t+2)
                        t <= t + LW'(1);
                        s <= s + t_ext + SW'(2);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
